// File: rtl/e1_rate_mon_if.sv
// E1 line-rate monitor bus: tick/enable/history-clear in, window status out.
// The monitor side uses the slave modport, the driving block the master.
interface e1_rate_mon_if #(
    parameter int CNT_W = 16
) ();
    logic             tick_in;
    logic             enable;
    logic             clear_hist;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_stb;
    logic             in_range;
    logic             los;
    logic [CNT_W-1:0] min_cnt;
    logic [CNT_W-1:0] max_cnt;

    modport master (
        output tick_in, enable, clear_hist,
        input  cnt_out, cnt_stb, in_range, los, min_cnt, max_cnt
    );

    modport slave (
        input  tick_in, enable, clear_hist,
        output cnt_out, cnt_stb, in_range, los, min_cnt, max_cnt
    );
endinterface

// File: rtl/e1_rate_mon.sv
// E1 line-rate monitor: gated tick count, tolerance flag, loss-of-clock flag.
// Optional min/max history is enabled by defining E1_RATE_MON_HIST_EN.
module e1_rate_mon #(
    parameter int GATE_CYCLES = 24000,
    parameter int NOMINAL     = 2048,
    parameter int TOL         = 16,
    parameter int CNT_W       = 16,
    parameter int LOS_CYCLES  = 64
) (
    input logic           clk,
    input logic           rst,
    e1_rate_mon_if.slave  bus
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int LW = $clog2(LOS_CYCLES + 1);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [LW-1:0]    LOS_MAX   = LW'(LOS_CYCLES);
    localparam logic [CNT_W:0]   LO_B = (NOMINAL > TOL) ?
                                        (CNT_W+1)'(NOMINAL - TOL) :
                                        (CNT_W+1)'(0);
    localparam logic [CNT_W:0]   HI_B = (CNT_W+1)'(NOMINAL + TOL);
    localparam logic [CNT_W-1:0] SAT  = '1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [GW-1:0]    r_gate;
    logic [CNT_W-1:0] r_acc;
    logic [LW-1:0]    r_los_cnt;
    logic [CNT_W-1:0] r_cnt_out;
    logic             r_cnt_stb;
    logic             r_in_range;
    logic             r_los;

    logic [GW-1:0]    w_gate;
    logic [CNT_W-1:0] w_acc;
    logic [CNT_W-1:0] w_acc_nx;
    logic             w_term;
    logic             w_close;
    logic             w_in_rng;

    // Entering RUN sees gate/accumulator as zero in that very cycle.
    assign w_gate   = (r_state == S_RUN) ? r_gate : '0;
    assign w_acc    = (r_state == S_RUN) ? r_acc  : '0;
    assign w_acc_nx = (bus.tick_in && (w_acc != SAT)) ? w_acc + 1'b1 : w_acc;
    assign w_term   = (w_gate == GATE_LAST);
    assign w_close  = bus.enable && w_term;
    assign w_in_rng = ({1'b0, w_acc_nx} >= LO_B) &&
                      ({1'b0, w_acc_nx} <= HI_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gate     <= '0;
            r_acc      <= '0;
            r_los_cnt  <= '0;
            r_cnt_out  <= '0;
            r_cnt_stb  <= 1'b0;
            r_in_range <= 1'b0;
            r_los      <= 1'b0;
        end else begin
            r_cnt_stb <= 1'b0;
            if (!bus.enable) begin
                r_state   <= S_IDLE;
                r_gate    <= '0;
                r_acc     <= '0;
                r_los_cnt <= '0;
                r_los     <= 1'b0;
            end else begin
                r_state <= S_RUN;
                if (w_term) begin
                    r_gate     <= '0;
                    r_acc      <= '0;
                    r_cnt_out  <= w_acc_nx;
                    r_cnt_stb  <= 1'b1;
                    r_in_range <= w_in_rng;
                end else begin
                    r_gate <= w_gate + 1'b1;
                    r_acc  <= w_acc_nx;
                end
                if (bus.tick_in) begin
                    r_los_cnt <= '0;
                    r_los     <= 1'b0;
                end else if (r_los_cnt != LOS_MAX) begin
                    r_los_cnt <= r_los_cnt + 1'b1;
                    if (r_los_cnt == LOS_MAX - 1'b1)
                        r_los <= 1'b1;
                end
            end
        end
    end

    assign bus.cnt_out  = r_cnt_out;
    assign bus.cnt_stb  = r_cnt_stb;
    assign bus.in_range = r_in_range;
    assign bus.los      = r_los;

`ifdef E1_RATE_MON_HIST_EN
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;

    // A clear coincident with a close seeds the history with that count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min <= '1;
            r_max <= '0;
        end else if (bus.clear_hist) begin
            r_min <= w_close ? w_acc_nx : '1;
            r_max <= w_close ? w_acc_nx : '0;
        end else if (w_close) begin
            if (w_acc_nx < r_min)
                r_min <= w_acc_nx;
            if (w_acc_nx > r_max)
                r_max <= w_acc_nx;
        end
    end

    assign bus.min_cnt = r_min;
    assign bus.max_cnt = r_max;
`else
    logic w_unused_clr;
    assign w_unused_clr = bus.clear_hist;
    assign bus.min_cnt  = '0;
    assign bus.max_cnt  = '0;
`endif
endmodule

// File: tb/tb_e1_rate_mon.sv
// Directed bench for e1_rate_mon: an 8-bit and a 6-bit counter instance
// driven in lockstep; history checks follow E1_RATE_MON_HIST_EN.
module tb_e1_rate_mon;
    logic clk;
    logic rst;
    logic tick;
    logic en;
    logic clr;

    int vec_cnt;
    int miscompares;
    int nstb;
    int stb_at;

`ifdef E1_RATE_MON_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    e1_rate_mon_if #(.CNT_W(8)) b8 ();
    e1_rate_mon_if #(.CNT_W(6)) b6 ();

    assign b8.tick_in    = tick;
    assign b8.enable     = en;
    assign b8.clear_hist = clr;
    assign b6.tick_in    = tick;
    assign b6.enable     = en;
    assign b6.clear_hist = clr;

    e1_rate_mon #(
        .GATE_CYCLES(100), .NOMINAL(25), .TOL(2),
        .CNT_W(8), .LOS_CYCLES(10)
    ) u_dut8 (
        .clk(clk), .rst(rst), .bus(b8)
    );

    e1_rate_mon #(
        .GATE_CYCLES(100), .NOMINAL(25), .TOL(2),
        .CNT_W(6), .LOS_CYCLES(10)
    ) u_dut6 (
        .clk(clk), .rst(rst), .bus(b6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: tick when k%n==n-1; 1: tick for k<n; 2: terminal tick only;
    // 3: tick every cycle; 4: ticks at k=0 and k=20 with LOS probes.
    task automatic run_win(input int mode, input int n, input int len,
                           input int clr_at);
        nstb   = 0;
        stb_at = -1;
        for (int k = 0; k < len; k++) begin
            en  = 1'b1;
            clr = (k == clr_at);
            case (mode)
                0:       tick = ((k % n) == (n - 1));
                1:       tick = (k < n);
                2:       tick = (k == 99);
                3:       tick = 1'b1;
                default: tick = (k == 0) || (k == 20);
            endcase
            step();
            if (b8.cnt_stb) begin
                nstb++;
                stb_at = k;
            end
            if (mode == 4) begin
                if (k == 0)  chk("los_clr_k0",  b8.los, 0);
                if (k == 9)  chk("los_k9",      b8.los, 0);
                if (k == 10) chk("los_k10",     b8.los, 1);
                if (k == 19) chk("los_k19",     b8.los, 1);
                if (k == 20) chk("los_fall",    b8.los, 0);
            end
        end
        tick = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic win_chk(input string tag, input int cnt, input bit rng);
        chk({tag, "_nstb"},  nstb, 1);
        chk({tag, "_stbat"}, stb_at, 99);
        chk({tag, "_cnt"},   b8.cnt_out, cnt);
        chk({tag, "_rng"},   b8.in_range, rng);
    endtask

    task automatic hist_chk(input string tag, input int mn, input int mx);
        chk({tag, "_min"}, b8.min_cnt, HIST ? mn : 0);
        chk({tag, "_max"}, b8.max_cnt, HIST ? mx : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_cnt     = 0;
        miscompares = 0;
        rst  = 1'b1;
        tick = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        repeat (3) step();
        chk("rst_cnt", b8.cnt_out, 0);
        chk("rst_stb", b8.cnt_stb, 0);
        chk("rst_rng", b8.in_range, 0);
        chk("rst_los", b8.los, 0);
        hist_chk("rst", 255, 0);
        rst = 1'b0;

        run_win(0, 4, 100, -1);
        win_chk("every4", 25, 1);
        chk("every4_los", b8.los, 0);
        hist_chk("every4", 25, 25);

        run_win(0, 3, 100, -1);
        win_chk("every3", 33, 0);
        hist_chk("every3", 25, 33);

        run_win(1, 27, 100, -1);
        win_chk("hi_edge", 27, 1);
        chk("gap_los", b8.los, 1);
        run_win(1, 28, 100, -1);
        win_chk("hi_out", 28, 0);
        run_win(1, 23, 100, -1);
        win_chk("lo_edge", 23, 1);
        run_win(1, 22, 100, -1);
        win_chk("lo_out", 22, 0);
        hist_chk("bounds", 22, 33);

        run_win(4, 0, 100, -1);
        win_chk("losgap", 2, 0);

        run_win(3, 0, 100, -1);
        win_chk("sat8", 100, 0);
        chk("sat6_cnt", b6.cnt_out, 63);
        hist_chk("sat", 2, 100);

        run_win(2, 0, 100, 99);
        win_chk("term", 1, 0);
        chk("term6_cnt", b6.cnt_out, 1);
        hist_chk("term_clr", 1, 1);

        run_win(1, 0, 100, -1);
        win_chk("restart", 0, 0);
        hist_chk("restart", 0, 1);

        run_win(0, 4, 100, 50);
        win_chk("midclr", 25, 1);
        hist_chk("midclr", 25, 25);

        run_win(1, 0, 50, -1);
        chk("abort_nstb", nstb, 0);
        chk("abort_los", b8.los, 1);
        nstb = 0;
        for (int k = 0; k < 5; k++) begin
            en = 1'b0;
            step();
            if (b8.cnt_stb) nstb++;
        end
        chk("idle_nstb", nstb, 0);
        chk("idle_los", b8.los, 0);
        chk("idle_cnt", b8.cnt_out, 25);
        chk("idle_rng", b8.in_range, 1);
        run_win(0, 4, 100, -1);
        win_chk("reraise", 25, 1);

        run_win(0, 4, 30, -1);
        chk("pre_rst_nstb", nstb, 0);
        rst = 1'b1;
        step();
        chk("mrst_cnt", b8.cnt_out, 0);
        chk("mrst_stb", b8.cnt_stb, 0);
        chk("mrst_rng", b8.in_range, 0);
        chk("mrst_los", b8.los, 0);
        hist_chk("mrst", 255, 0);
        rst = 1'b0;
        en  = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, miscompares);
        $finish;
    end
endmodule
